// File: rtl/mvu_job_dispatcher.sv
// Per-MVU job queues feeding one launch sequencer per MVU: pop a packed job,
// pulse start, wait for the MVU irq (or the watchdog), then report back.
module mvu_job_dispatcher #(
  parameter int NMVU    = 8,
  parameter int BMVUA   = $clog2(NMVU),
  parameter int CFGW    = 128,
  parameter int QDEPTH  = 4,
  parameter int BQ      = $clog2(QDEPTH + 1),
  parameter int TIMEOUT = 65536,
  parameter int BTO     = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [BMVUA-1:0]     job_mvu,
  input  logic [CFGW-1:0]      job_cfg,
  input  logic [NMVU-1:0]      flush,
  output logic [NMVU-1:0]      mvu_start,
  output logic [NMVU*CFGW-1:0] mvu_cfg,
  input  logic [NMVU-1:0]      mvu_irq,
  output logic [NMVU-1:0]      done_irq,
  output logic [NMVU-1:0]      err,
  output logic [NMVU-1:0]      busy,
  output logic [NMVU*BQ-1:0]   q_level
);

  localparam int QA = $clog2(QDEPTH);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  logic [NMVU-1:0] full_vec;
  logic            sel_ok;

  // Out-of-range destinations match no queue, so they stay ready and get dropped.
  always_comb begin
    sel_ok = 1'b1;
    for (int i = 0; i < NMVU; i++) begin
      if (int'(job_mvu) == i) sel_ok = !full_vec[i] && !flush[i];
    end
    job_ready = rst_n && sel_ok;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NMVU; gi++) begin : g_mvu
      state_t          state_reg, state_next;
      logic [CFGW-1:0] mem [QDEPTH];
      logic [CFGW-1:0] cfg_reg;
      logic [BQ-1:0]   level_reg, level_next;
      logic [QA-1:0]   wr_ptr_reg, rd_ptr_reg;
      logic [BTO-1:0]  wd_reg, wd_next;
      logic            err_reg, err_next;
      logic            start_reg, start_next;
      logic            done_reg, done_next;
      logic            busy_reg;
      logic            push, pop;

      assign push          = job_valid && job_ready && (int'(job_mvu) == gi);
      assign full_vec[gi]  = (level_reg == BQ'(QDEPTH));

      always_comb begin
        state_next = state_reg;
        wd_next    = wd_reg;
        err_next   = err_reg;
        start_next = 1'b0;
        done_next  = 1'b0;
        pop        = 1'b0;
        if (flush[gi]) begin
          state_next = IDLE;
          err_next   = 1'b0;
          wd_next    = '0;
        end else begin
          case (state_reg)
            IDLE: begin
              if (level_reg != '0) begin
                pop        = 1'b1;
                start_next = 1'b1;
                state_next = START;
              end
            end
            START: begin
              wd_next    = '0;
              state_next = RUN;
            end
            RUN: begin
              // irq is checked first so it beats a same-cycle timeout
              if (mvu_irq[gi]) begin
                done_next  = 1'b1;
                state_next = IDLE;
              end else if (TIMEOUT != 0 && wd_reg == BTO'(TIMEOUT - 1)) begin
                err_next   = 1'b1;
                state_next = IDLE;
              end else begin
                wd_next = wd_reg + 1'b1;
              end
            end
            default: state_next = IDLE;
          endcase
        end
        level_next = flush[gi] ? '0 : level_reg + BQ'(push) - BQ'(pop);
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg  <= IDLE;
          level_reg  <= '0;
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          wd_reg     <= '0;
          err_reg    <= 1'b0;
          start_reg  <= 1'b0;
          done_reg   <= 1'b0;
          busy_reg   <= 1'b0;
          cfg_reg    <= '0;
        end else begin
          state_reg <= state_next;
          level_reg <= level_next;
          wd_reg    <= wd_next;
          err_reg   <= err_next;
          start_reg <= start_next;
          done_reg  <= done_next;
          busy_reg  <= (state_next != IDLE) || (level_next != '0);
          if (flush[gi]) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
          end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          end
          if (pop) cfg_reg <= mem[rd_ptr_reg];
        end
      end

      // Storage has no reset so it can map onto block RAM.
      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= job_cfg;
      end

      assign mvu_start[gi]            = start_reg;
      assign done_irq[gi]             = done_reg;
      assign err[gi]                  = err_reg;
      assign busy[gi]                 = busy_reg;
      assign mvu_cfg[gi*CFGW +: CFGW] = cfg_reg;
      assign q_level[gi*BQ +: BQ]     = level_reg;
    end
  endgenerate

endmodule

// File: tb/tb_mvu_job_dispatcher.sv
// Bench for mvu_job_dispatcher: directed scenarios plus random traffic, checked
// every cycle against a queue/timestamp model of the dispatcher.
module tb_mvu_job_dispatcher;
  localparam int N  = 8;
  localparam int W  = 32;
  localparam int QD = 4;
  localparam int TO = 16;
  localparam int BQ = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            job_valid;
  logic            job_ready;
  logic [3:0]      job_mvu;
  logic [W-1:0]    job_cfg;
  logic [N-1:0]    flush;
  logic [N-1:0]    mvu_start;
  logic [N*W-1:0]  mvu_cfg;
  logic [N-1:0]    mvu_irq;
  logic [N-1:0]    done_irq;
  logic [N-1:0]    err;
  logic [N-1:0]    busy;
  logic [N*BQ-1:0] q_level;

  mvu_job_dispatcher #(
    .NMVU(N), .BMVUA(4), .CFGW(W), .QDEPTH(QD), .BQ(BQ), .TIMEOUT(TO), .BTO(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_mvu(job_mvu), .job_cfg(job_cfg), .flush(flush), .mvu_start(mvu_start),
    .mvu_cfg(mvu_cfg), .mvu_irq(mvu_irq), .done_irq(done_irq), .err(err),
    .busy(busy), .q_level(q_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: pending jobs per MVU, plus whether a job is out and when it launched.
  logic [W-1:0] mq [N][$];
  bit           m_act [N];
  int           m_lc  [N];
  logic [W-1:0] m_cfg [N];
  bit           m_err [N];
  int           dly   [N];
  bit           last_acc;

  logic [N-1:0]    e_start, e_done, e_err, e_busy;
  logic [N*BQ-1:0] e_level;
  logic [N*W-1:0]  e_cfg;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic bit exp_ready();
    int jm;
    jm = int'(job_mvu);
    if (!rst_n) return 1'b0;
    if (jm >= N) return 1'b1;
    return (mq[jm].size() < QD) && !flush[jm];
  endfunction

  // One clock: check job_ready, advance the model across the edge, check outputs.
  task automatic step();
    bit rdy;
    int jm;
    #1;
    rdy = exp_ready();
    chk("job_ready", job_ready, rdy);
    jm = int'(job_mvu);
    last_acc = job_valid && rdy;
    for (int i = 0; i < N; i++) begin
      e_start[i] = 1'b0;
      e_done[i]  = 1'b0;
      if (!rst_n) begin
        mq[i].delete(); m_act[i] = 0; m_err[i] = 0; m_cfg[i] = '0;
      end else if (flush[i]) begin
        mq[i].delete(); m_act[i] = 0; m_err[i] = 0;
      end else begin
        if (m_act[i] && cyc > m_lc[i] && mvu_irq[i]) begin
          m_act[i] = 0; e_done[i] = 1'b1;
        end else if (m_act[i] && cyc == m_lc[i] + TO) begin
          m_act[i] = 0; m_err[i] = 1;
        end else if (!m_act[i] && mq[i].size() > 0) begin
          m_cfg[i] = mq[i].pop_front(); m_act[i] = 1; m_lc[i] = cyc + 1; e_start[i] = 1'b1;
        end
        if (last_acc && jm == i) begin
          mq[i].push_back(job_cfg);
          $display("cycle %0d push mvu=%0d cfg=%h", cyc, i, job_cfg);
        end
      end
      e_err[i]            = m_err[i];
      e_busy[i]           = m_act[i] || (mq[i].size() != 0);
      e_level[i*BQ +: BQ] = BQ'(mq[i].size());
      e_cfg[i*W +: W]     = m_cfg[i];
    end
    if (last_acc && jm >= N) $display("cycle %0d discard mvu=%0d cfg=%h", cyc, jm, job_cfg);
    @(posedge clk);
    #1;
    cyc++;
    chk("mvu_start", mvu_start, e_start);
    chk("mvu_cfg", mvu_cfg, e_cfg);
    chk("done_irq", done_irq, e_done);
    chk("err", err, e_err);
    chk("busy", busy, e_busy);
    chk("q_level", q_level, e_level);
  endtask

  task automatic push(input int m, input logic [W-1:0] c);
    job_valid = 1'b1; job_mvu = 4'(m); job_cfg = c;
    step();
    job_valid = 1'b0;
  endtask

  task automatic wait_run(input int i);
    for (int k = 0; k < 40 && !(m_act[i] && cyc > m_lc[i]); k++) step();
    chk("wait_run", busy[i], 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, lc, k;
    rst_n = 1'b0; job_valid = 1'b0; job_mvu = '0; job_cfg = '0; flush = '0; mvu_irq = '0;
    for (int i = 0; i < N; i++) begin m_act[i] = 0; m_lc[i] = 0; m_cfg[i] = '0; m_err[i] = 0; dly[i] = 1; end
    repeat (3) step();
    chk("rst_busy", busy, 8'h00);
    rst_n = 1'b1;
    step();

    // Single job on MVU 2: launch latency and completion
    t0 = cyc;
    push(2, 32'hA5);
    chk("t1_level", q_level[8:6], 3'd1);
    step();
    chk("t1_start", mvu_start, 8'b0000_0100);
    chk("t1_cfg", mvu_cfg[95:64], 32'hA5);
    while (cyc < t0 + 10) step();
    mvu_irq[2] = 1'b1; step(); mvu_irq[2] = 1'b0;
    chk("t1_done", done_irq, 8'b0000_0100);
    chk("t1_busy", busy[2], 1'b0);

    // Five jobs back to back on MVU 0, queue fills, then drains in order
    job_valid = 1'b1; job_mvu = 4'd0; k = 0;
    for (int n = 0; n < 40 && k < 5; n++) begin
      job_cfg = 32'h100 + 32'(k);
      step();
      if (last_acc) k++;
    end
    job_valid = 1'b0;
    chk("t2_level", q_level[2:0], 3'd4);
    job_valid = 1'b1; job_cfg = 32'h1FF; #1;
    chk("t2_full_ready", job_ready, 1'b0);
    job_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      wait_run(0);
      step(); step();
      mvu_irq[0] = 1'b1; step(); mvu_irq[0] = 1'b0;
      chk("t2_done", done_irq[0], 1'b1);
      chk("t2_order", mvu_cfg[31:0], 32'h100 + 32'(j));
    end

    // Watchdog on MVU 1
    push(1, 32'h1111);
    wait_run(1);
    lc = m_lc[1];
    for (int n = 0; n < 40 && cyc < lc + TO; n++) step();
    chk("t3_err_early", err[1], 1'b0);
    step();
    chk("t3_err", err[1], 1'b1);
    chk("t3_idle", busy[1], 1'b0);
    mvu_irq[1] = 1'b1; step(); mvu_irq[1] = 1'b0;
    chk("t3_late_irq", done_irq[1], 1'b0);
    flush[1] = 1'b1; step(); flush[1] = 1'b0;
    chk("t3_flush_err", err[1], 1'b0);

    // Flush MVU 3 while running with two queued, with a job offered at once
    push(3, 32'h3330); push(3, 32'h3331); push(3, 32'h3332);
    wait_run(3);
    flush[3] = 1'b1; job_valid = 1'b1; job_mvu = 4'd3; job_cfg = 32'h3333; #1;
    chk("t4_ready", job_ready, 1'b0);
    step();
    flush[3] = 1'b0; job_valid = 1'b0;
    chk("t4_level", q_level[11:9], 3'd0);
    chk("t4_cfg_kept", mvu_cfg[127:96], 32'h3330);
    mvu_irq[3] = 1'b1; step(); mvu_irq[3] = 1'b0;
    chk("t4_irq_ignored", done_irq[3], 1'b0);
    repeat (3) step();

    // Random interleaved traffic, including out-of-range destinations
    for (int n = 0; n < 800; n++) begin
      job_valid = ($urandom_range(0, 2) != 0);
      job_mvu   = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 8));
      job_cfg   = $urandom;
      flush     = ($urandom_range(0, 99) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      for (int i = 0; i < N; i++) begin
        if (m_act[i] && cyc == m_lc[i]) dly[i] = int'($urandom_range(1, 18));
        if (m_act[i] && cyc > m_lc[i]) mvu_irq[i] = (cyc - m_lc[i] >= dly[i]);
        else                           mvu_irq[i] = ($urandom_range(0, 15) == 0);
      end
      step();
    end
    job_valid = 1'b0; flush = '0; mvu_irq = '0;
    repeat (20) step();

    // Reset while MVU 4 runs with three queued
    push(4, 32'h4440); push(4, 32'h4441); push(4, 32'h4442); push(4, 32'h4443);
    wait_run(4);
    rst_n = 1'b0;
    step();
    chk("t6_start", mvu_start, 8'h00);
    chk("t6_cfg", mvu_cfg, 256'h0);
    chk("t6_done", done_irq, 8'h00);
    chk("t6_busy", busy, 8'h00);
    chk("t6_level", q_level, 24'h0);
    chk("t6_ready", job_ready, 1'b0);
    mvu_irq[4] = 1'b1; step(); mvu_irq[4] = 1'b0;
    rst_n = 1'b1;
    step();
    chk("t6_no_done", done_irq, 8'h00);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
